// File: rtl/spi_slave.sv
// SPI mode-0 slave: command byte followed by data bytes; response bytes are
// driven on MISO from a 64-bit word latched when the command byte completes.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_ssel_n,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [7:0]  spi_cmd,
  output logic [63:0] spi_rxdata,
  output logic        spi_msg_end,
  input  logic [63:0] spi_txdata,
  input  logic        spi_txdata_valid
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  logic [SYNC_STAGES-1:0] ssel_sync_reg, sclk_sync_reg, mosi_sync_reg, flush_reg;
  logic ssel_d_reg, sclk_d_reg, armed_reg;
  logic ssel_s, sclk_s, mosi_s;
  logic ssel_fall, ssel_rise, sclk_rise, sclk_fall;

  assign ssel_s = ssel_sync_reg[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

  // armed_reg blocks a false select edge when reset is released with
  // ssel_n already low: a message only starts after ssel_n was seen high.
  assign ssel_fall = armed_reg & ssel_d_reg & ~ssel_s;
  assign ssel_rise = ~ssel_d_reg & ssel_s;
  assign sclk_rise = ~sclk_d_reg & sclk_s;
  assign sclk_fall = sclk_d_reg & ~sclk_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ssel_sync_reg <= '1;
      sclk_sync_reg <= '0;
      mosi_sync_reg <= '0;
      flush_reg     <= '0;
      ssel_d_reg    <= 1'b1;
      sclk_d_reg    <= 1'b0;
      armed_reg     <= 1'b0;
    end else begin
      ssel_sync_reg <= {ssel_sync_reg[SYNC_STAGES-2:0], spi_ssel_n};
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
      flush_reg     <= {flush_reg[SYNC_STAGES-2:0], 1'b1};
      ssel_d_reg    <= ssel_s;
      sclk_d_reg    <= sclk_s;
      if (flush_reg[SYNC_STAGES-1] && ssel_s)
        armed_reg <= 1'b1;
    end
  end

  state_t      state_reg, state_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [6:0]  shift_reg, shift_next;
  logic [7:0]  cmd_reg, cmd_next;
  logic [63:0] rx_reg, rx_next;
  logic [63:0] tx_reg, tx_next;
  logic        miso_reg, miso_next;
  logic        msg_end_reg, msg_end_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      cmd_reg     <= '0;
      rx_reg      <= '0;
      tx_reg      <= '0;
      miso_reg    <= 1'b0;
      msg_end_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      cmd_reg     <= cmd_next;
      rx_reg      <= rx_next;
      tx_reg      <= tx_next;
      miso_reg    <= miso_next;
      msg_end_reg <= msg_end_next;
    end
  end

  logic       start, busy;
  logic [2:0] cnt_base;
  logic [7:0] rx_byte, tx_byte;

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    cmd_next     = cmd_reg;
    rx_next      = rx_reg;
    tx_next      = tx_reg;
    miso_next    = miso_reg;
    msg_end_next = 1'b0;

    start    = (state_reg == IDLE) && ssel_fall;
    busy     = (state_reg != IDLE) && !ssel_rise;
    // An SCLK edge coinciding with the select edge is the message's first bit.
    cnt_base = start ? 3'd0 : bit_cnt_reg;
    rx_byte  = {shift_reg, mosi_s};
    tx_byte  = tx_reg[7:0];

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = CMD;
          bit_cnt_next = 3'd0;
          rx_next      = '0;
          tx_next      = '0;
          miso_next    = 1'b0;
        end
      end
      CMD, DATA: begin
        if (ssel_rise) begin
          state_next   = IDLE;
          msg_end_next = 1'b1;
          miso_next    = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    if ((start || busy) && sclk_rise) begin
      shift_next   = rx_byte[6:0];
      bit_cnt_next = cnt_base + 3'd1;
      if (cnt_base == 3'd7) begin
        if (state_reg == DATA) begin
          rx_next = {rx_byte, rx_reg[63:8]};
          tx_next = {8'h00, tx_reg[63:8]};
        end else begin
          cmd_next   = rx_byte;
          tx_next    = spi_txdata_valid ? spi_txdata : 64'h0;
          state_next = DATA;
        end
      end
    end

    // bit_cnt counts bits already taken, so ~bit_cnt selects the next one to send.
    if (busy && (state_reg == DATA) && sclk_fall)
      miso_next = tx_byte[~bit_cnt_reg];
  end

  assign spi_miso    = miso_reg;
  assign spi_cmd     = cmd_reg;
  assign spi_rxdata  = rx_reg;
  assign spi_msg_end = msg_end_reg;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a bit-banged SPI master plus a message-level
// reference model; a monitor checks each spi_msg_end against queued expectations.
module tb_spi_slave;

  localparam int HALF = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_ssel_n, spi_sclk, spi_mosi, spi_miso;
  logic [7:0]  spi_cmd;
  logic [63:0] spi_rxdata;
  logic        spi_msg_end;
  logic [63:0] spi_txdata;
  logic        spi_txdata_valid;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .spi_ssel_n(spi_ssel_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_cmd(spi_cmd), .spi_rxdata(spi_rxdata),
    .spi_msg_end(spi_msg_end), .spi_txdata(spi_txdata),
    .spi_txdata_valid(spi_txdata_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   cmd;
    logic [63:0]  rx;
    int           nb;
    logic [127:0] miso;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [7:0]   msg [16];
  logic [127:0] miso_obs_vec;
  logic [7:0]   model_cmd = 8'h00;
  int           tests = 0;
  int           fails = 0;
  int           msg_no = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference model: message-level view of what the slave must report.
  task automatic push_exp(input int nbits, input bit valid, input logic [63:0] txd);
    exp_t e;
    int nfull, nd;
    nfull = nbits / 8;
    if (nfull >= 1) model_cmd = msg[0];
    nd = (nfull >= 1) ? nfull - 1 : 0;
    e.cmd  = model_cmd;
    e.rx   = '0;
    e.nb   = nfull;
    e.miso = '0;
    for (int k = 0; k < 8; k++)
      if (k < nd) e.rx[63-8*k -: 8] = msg[nd-k];
    for (int j = 1; j < nfull; j++)
      if (valid && (j - 1) < 8) e.miso[8*j +: 8] = txd[8*(j-1) +: 8];
    exp_q.push_back(e);
  endtask

  task automatic spi_msg(input int nbits, input bit coincident, input bit finish_sel);
    logic [7:0] cur, b;
    int nobs;
    cur = '0;
    nobs = 0;
    miso_obs_vec = '0;
    #7;
    if (!(coincident && nbits > 0)) spi_ssel_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      b = msg[i/8];
      if (i == 0 && coincident) begin
        spi_ssel_n = 1'b0;
        spi_mosi   = b[7];
        cur        = {cur[6:0], spi_miso};
        spi_sclk   = 1'b1;
      end else begin
        spi_mosi = b[7 - (i % 8)];
        #HALF;
        cur      = {cur[6:0], spi_miso};
        spi_sclk = 1'b1;
      end
      #HALF;
      spi_sclk = 1'b0;
      if (i % 8 == 7) begin
        miso_obs_vec[8*nobs +: 8] = cur;
        nobs++;
      end
    end
    #HALF;
    if (finish_sel) begin
      spi_ssel_n = 1'b1;
      spi_mosi   = 1'b0;
      #(4*HALF);
    end
  endtask

  task automatic run_msg(input int nbits, input bit coincident, input bit valid, input logic [63:0] txd);
    spi_txdata       = txd;
    spi_txdata_valid = valid;
    push_exp(nbits, valid, txd);
    spi_msg(nbits, coincident, 1'b1);
  endtask

  always @(negedge clk) begin
    if (!reset && spi_msg_end) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_msg_end: got a pulse, required none");
      end else begin
        mon_e = exp_q.pop_front();
        msg_no++;
        check("cmd", {56'h0, spi_cmd}, {56'h0, mon_e.cmd});
        check("rxdata", spi_rxdata, mon_e.rx);
        for (int j = 0; j < mon_e.nb; j++)
          check("miso_byte", {56'h0, miso_obs_vec[8*j +: 8]}, {56'h0, mon_e.miso[8*j +: 8]});
        $display("[TB] msg %0d: cmd=%02h rxdata=%016h bytes=%0d", msg_no, spi_cmd, spi_rxdata, mon_e.nb);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; spi_ssel_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    spi_txdata = '0; spi_txdata_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cmd", {56'h0, spi_cmd}, 64'h0);
    check("reset_rxdata", spi_rxdata, 64'h0);
    check("reset_miso", {63'h0, spi_miso}, 64'h0);
    check("reset_msg_end", {63'h0, spi_msg_end}, 64'h0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    msg[0] = 8'h02; msg[1] = 8'h01;
    run_msg(16, 0, 0, 64'h0);
    msg[0] = 8'h11; msg[1] = 8'hFE; msg[2] = 8'hFD;
    run_msg(24, 0, 0, 64'h0);
    msg[0] = 8'h10;
    for (int i = 0; i < 9; i++) msg[i+1] = 8'(i);
    run_msg(72, 0, 0, 64'h0);
    run_msg(80, 0, 0, 64'h0);
    msg[0] = 8'h20;
    for (int i = 1; i < 4; i++) msg[i] = 8'($urandom);
    run_msg(32, 0, 1, 64'h1122334455667788);
    run_msg(32, 0, 0, 64'h1122334455667788);
    // Select released 5 bits into the third data byte, then mid-command.
    msg[0] = 8'h33; msg[1] = 8'hA5; msg[2] = 8'h5A; msg[3] = 8'hFF;
    run_msg(29, 0, 1, 64'hCAFEF00DDEADBEEF);
    msg[0] = 8'h77;
    run_msg(5, 0, 0, 64'h0);
    run_msg(0, 0, 0, 64'h0);
    msg[0] = 8'h44;
    run_msg(8, 0, 1, 64'h0123456789ABCDEF);
    msg[0] = 8'hC3; msg[1] = 8'h96;
    run_msg(16, 1, 1, 64'h00000000000000E1);

    // SCLK activity while deselected must be ignored.
    for (int i = 0; i < 10; i++) begin
      spi_mosi = 1'($urandom);
      #HALF; spi_sclk = 1'b1;
      #HALF; spi_sclk = 1'b0;
    end
    repeat (5) @(negedge clk);
    check("idle_sclk_cmd", {56'h0, spi_cmd}, {56'h0, model_cmd});

    // Reset 12 bits into a message; the rest of it must be ignored.
    msg[0] = 8'h5E; msg[1] = 8'h81;
    spi_msg(12, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_cmd", {56'h0, spi_cmd}, 64'h0);
    check("midreset_rxdata", spi_rxdata, 64'h0);
    check("midreset_miso", {63'h0, spi_miso}, 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_cmd = 8'h00;
    spi_msg(4, 0, 0);
    spi_ssel_n = 1'b1;
    repeat (20) @(negedge clk);
    check("postreset_cmd", {56'h0, spi_cmd}, 64'h0);
    check("postreset_rxdata", spi_rxdata, 64'h0);
    msg[0] = 8'h01; msg[1] = 8'h01;
    run_msg(16, 0, 0, 64'h0);

    for (int t = 0; t < 20; t++) begin
      int nbits;
      nbits = $urandom_range(0, 96);
      for (int i = 0; i < 12; i++) msg[i] = 8'($urandom);
      run_msg(nbits, (nbits > 0) && ($urandom_range(0, 3) == 0), 1'($urandom),
              {$urandom, $urandom});
    end

    repeat (20) @(negedge clk);
    check("pending_expectations", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchroniser flop count on spi_ssel_n, spi_sclk and spi_mosi (minimum 2).
REQ-002 SHALL have port clk, input, 1: system clock, at least 4x the SPI SCLK rate.
REQ-003 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port spi_ssel_n, input, 1: SPI chip select from the ESP32, active-low, asynchronous to clk.
REQ-005 SHALL have port spi_sclk, input, 1: SPI clock, mode 0 (idle low), asynchronous to clk.
REQ-006 SHALL have port spi_mosi, input, 1: serial data in, MSB-first per byte.
REQ-007 SHALL have port spi_miso, output, 1: serial data out, MSB-first per byte.
REQ-008 SHALL have port spi_cmd, output, 8: first byte of the current or most recent message.
REQ-009 SHALL have port spi_rxdata, output, 64: data bytes following the command byte.
REQ-010 SHALL have port spi_msg_end, output, 1: one-clk pulse at message end.
REQ-011 SHALL have port spi_txdata, input, 64: response bytes for the current command.
REQ-012 SHALL have port spi_txdata_valid, input, 1: qualifies spi_txdata.

Function
REQ-013 SHALL pass spi_ssel_n, spi_sclk and spi_mosi through SYNC_STAGES flops; all logic SHALL use only the synchronised copies.
REQ-014 SHALL detect SCLK rising and falling edges by comparing the synchronised SCLK with a one-clk-delayed copy.
REQ-015 SHALL use the states IDLE, CMD and DATA.
- IDLE: wait for synchronised ssel_n to fall, then go to CMD.
- CMD: receive the command byte, then go to DATA.
- DATA: receive data bytes.
- From CMD or DATA: return to IDLE on synchronised ssel_n rising.
REQ-016 On the ssel_n falling edge, SHALL clear the bit counter (3 bits), spi_rxdata (to 0) and the tx shift register (to 0).
REQ-017 SHALL sample MOSI on each SCLK rising edge while selected, shifting into an 8-bit register MSB-first.
REQ-018 When the 8th bit of a byte is sampled, SHALL act on the completed byte in the same cycle.
- In CMD: write the byte to spi_cmd.
- In DATA: update spi_rxdata <= {byte, spi_rxdata[63:8]}.
REQ-019 Byte placement SHALL follow from that shift: the first data byte lands in [63:56] after 1 byte, in [55:48] after 2 bytes, and in [7:0] after 8 bytes.
REQ-020 Data bytes beyond 8 SHALL keep shifting; the oldest byte is discarded.
REQ-021 spi_cmd SHALL hold its value until the next command byte completes; it SHALL NOT be cleared at message start.
REQ-022 On command-byte completion, SHALL load the tx shift register with spi_txdata if spi_txdata_valid is 1, else with 0.
REQ-023 In DATA, SHALL update spi_miso on each SCLK falling edge to the current MSB of the tx byte, taken from tx register bits [7:0].
REQ-024 After each full data byte, SHALL shift the tx register right by 8 and fill the top with zeros.
REQ-025 The first MISO bit of the first data byte SHALL be valid before the first SCLK rising edge of that byte.
REQ-026 spi_miso SHALL be 0 in IDLE and throughout the command byte.
REQ-027 On the synchronised ssel_n rising edge, SHALL pulse spi_msg_end high for exactly one clk, whether the message holds zero or more data bytes.
REQ-028 spi_cmd and spi_rxdata SHALL be stable during the spi_msg_end pulse.
REQ-029 If ssel_n rises mid-byte, SHALL discard the partial bits; spi_rxdata and spi_cmd keep their last complete values and spi_msg_end still pulses.
REQ-030 If ssel_n rises during the command byte, SHALL still pulse spi_msg_end, with spi_cmd holding the previous command.
REQ-031 SCLK edges while ssel_n is high SHALL have no effect.
REQ-032 An ssel_n fall that coincides with an SCLK edge SHALL treat the edge as the first bit of the message.
REQ-033 A new message SHALL be accepted starting 1 clk after the spi_msg_end pulse.

Reset
REQ-034 Asynchronous reset SHALL force: state IDLE, spi_cmd=0x00, spi_rxdata=0, spi_msg_end=0, spi_miso=0, bit counter 0, tx register 0, and all synchroniser flops to the idle values (ssel_n=1, sclk=0, mosi=0).
REQ-035 Reset released mid-message SHALL remain in IDLE until the next ssel_n falling edge; no spi_msg_end pulse occurs for the interrupted message.

Verification
REQ-036 Send 0x02, 0x01 -> spi_cmd=0x02, spi_rxdata[63:56]=0x01, one spi_msg_end pulse.
REQ-037 Send 0x11, 0xFE, 0xFD -> spi_rxdata[63:48]=0xFDFE, spi_cmd=0x11.
REQ-038 Send 0x10 plus 8 bytes 0x00..0x07 -> spi_rxdata=0x0706050403020100; then send 9 bytes 0x00..0x08 -> 0x0807060504030201.
REQ-039 Send command 0x20 with spi_txdata=0x1122334455667788 and spi_txdata_valid=1, clock 3 bytes -> MISO returns 0x88, 0x77, 0x66; repeat with spi_txdata_valid=0 -> MISO returns 0x00, 0x00, 0x00.
REQ-040 Deassert ssel_n after 5 bits of a data byte -> spi_msg_end pulses once and spi_rxdata keeps the prior bytes only.
REQ-041 Assert reset after 12 bits of a message, then release -> all outputs at reset values, no spi_msg_end; the next full message 0x01, 0x01 decodes correctly.
